// File: rtl/uart_pkg.sv
// Shared UART transmit encodings: select codes for the TX output mux and line levels.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// The TX control FSM drives the same select codes, so both sides of the
// s1/s0 pair agree on the meaning of each bit-time slot.
package uart_pkg;

    // Bit-time slot selected on the serial line, encoded as {s1, s0}.
    typedef enum logic [1:0] {
        SEL_START  = 2'b00,
        SEL_DATA   = 2'b01,
        SEL_PARITY = 2'b10,
        SEL_STOP   = 2'b11
    } tx_sel_e;

    // Mark (idle/stop) and space (start) levels of an RS-232 style line.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage : uart_pkg

// File: rtl/tx_mux_if.sv
// Signal bundle between the TX shift/parity logic, the output mux and the pad.
// Latency: n/a (wiring only).
// Backpressure: none; the control FSM holds selects stable for a whole bit period.
//
// Signals:
//   data_bit, parity_bit : serial data and parity levels from the shift register
//   s0, s1               : slot select from the TX control FSM ({s1, s0})
//   tx_packet            : combinational selected level
//   tx_line              : registered, glitch-free level toward the TX pin
interface tx_mux_if;

    logic data_bit;
    logic parity_bit;
    logic s0;
    logic s1;
    logic tx_packet;
    logic tx_line;

    // Transmit control side: drives data/select, observes the line.
    modport master (
        output data_bit,
        output parity_bit,
        output s0,
        output s1,
        input  tx_packet,
        input  tx_line
    );

    // Output mux side: consumes data/select, produces the line.
    modport slave (
        input  data_bit,
        input  parity_bit,
        input  s0,
        input  s1,
        output tx_packet,
        output tx_line
    );

endinterface : tx_mux_if

// File: rtl/tx_mux.sv
// UART TX output selector: picks start/data/parity/stop level and registers it for the pin.
// Latency: tx_packet combinational (0 cycles); tx_line one clk cycle.
// Backpressure: none; selects are held stable by the control FSM for a full bit period.
//
// Ports (declaration order kept so 5-port positional instances still bind):
//   data_bit   in  : current serial data bit
//   parity_bit in  : precomputed parity bit
//   s0, s1     in  : slot select, decoded as {s1, s0}
//   tx_packet  out : combinational selected level (independent of clk/rst_n)
//   clk        in  : clock, used only by the tx_line flop
//   rst_n      in  : asynchronous active-low reset, forces tx_line to IDLE_LEVEL
//   tx_line    out : registered copy of tx_packet, drives the TX pad
module tx_mux
    import uart_pkg::*;
#(
    parameter logic IDLE_LEVEL = LINE_IDLE
) (
    input  logic data_bit,
    input  logic parity_bit,
    input  logic s0,
    input  logic s1,
    output logic tx_packet,
    input  logic clk,
    input  logic rst_n,
    output logic tx_line
);

    logic tx_line_d;
    logic tx_line_q;

    // Slot decode. The case is fully covered for 0/1 selects; an X/Z on
    // either select matches no item, so the X preset survives and the
    // unknown select is visible in simulation instead of being masked.
    // Start and stop are constants and never look at data/parity.
    always_comb begin
        tx_packet = 1'bx;
        case ({s1, s0})
            SEL_START:  tx_packet = LINE_START;
            SEL_DATA:   tx_packet = data_bit;
            SEL_PARITY: tx_packet = parity_bit;
            SEL_STOP:   tx_packet = LINE_IDLE;
        endcase
    end

    assign tx_line_d = tx_packet;

    // Only edge-sampled values reach the pin, so decode glitches between
    // edges are filtered. Reset parks the line at mark without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_line_q <= IDLE_LEVEL;
        end else begin
            tx_line_q <= tx_line_d;
        end
    end

    assign tx_line = tx_line_q;

endmodule : tx_mux

// File: tb/tb_tx_mux.sv
// Directed bench for tx_mux: decode sweep, input isolation, registered path,
// async reset and a full 0xA5 even-parity frame, checked through a scoreboard queue.
module tb_tx_mux;
    import uart_pkg::*;

    logic clk;
    logic rst_n;

    tx_mux_if bus ();

    tx_mux #(
        .IDLE_LEVEL (LINE_IDLE)
    ) dut (
        .data_bit   (bus.data_bit),
        .parity_bit (bus.parity_bit),
        .s0         (bus.s0),
        .s1         (bus.s1),
        .tx_packet  (bus.tx_packet),
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_line    (bus.tx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    // Pop the oldest expectation and compare against the observed level.
    task automatic chk(input string tag, input logic obs);
        logic exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic d, input logic p);
        bus.s1         = sel[1];
        bus.s0         = sel[0];
        bus.data_bit   = d;
        bus.parity_bit = p;
    endtask

    logic [1:0] sweep [4];
    logic       exp_hi [4];
    logic       exp_lo [4];
    logic [7:0] frame_byte;
    logic [1:0] frame_sel [11];
    logic       frame_d   [11];
    logic       frame_exp [11];
    logic       par;

    initial begin
        sweep  = '{SEL_START, SEL_DATA, SEL_PARITY, SEL_STOP};
        exp_hi = '{1'b0, 1'b1, 1'b0, 1'b1};   // data=1, parity=0
        exp_lo = '{1'b0, 1'b0, 1'b1, 1'b1};   // data=0, parity=1

        rst_n = 1'b0;
        drive(SEL_STOP, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(1'b1);
        chk("reset_line_idle", bus.tx_line);

        // Combinational decode sweeps (clock-independent, done under reset).
        for (int i = 0; i < 4; i++) begin
            drive(sweep[i], 1'b1, 1'b0);
            exp_q.push_back(exp_hi[i]);
            #2;
            chk($sformatf("decode_d1p0_sel%0d", i), bus.tx_packet);
        end
        for (int i = 0; i < 4; i++) begin
            drive(sweep[i], 1'b0, 1'b1);
            exp_q.push_back(exp_lo[i]);
            #2;
            chk($sformatf("decode_d0p1_sel%0d", i), bus.tx_packet);
        end

        // Unselected inputs must not move the output.
        for (int i = 0; i < 4; i++) begin
            drive(SEL_START, i[0], i[1]);
            exp_q.push_back(1'b0);
            #2;
            chk($sformatf("iso_start_%0d", i), bus.tx_packet);
        end
        for (int i = 0; i < 4; i++) begin
            drive(SEL_STOP, i[0], i[1]);
            exp_q.push_back(1'b1);
            #2;
            chk($sformatf("iso_stop_%0d", i), bus.tx_packet);
        end

        // Registered path: release reset, select DATA=0, line moves only at the edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(SEL_DATA, 1'b0, 1'b1);
        #2;
        exp_q.push_back(1'b0);
        chk("reg_packet_now", bus.tx_packet);
        exp_q.push_back(1'b1);
        chk("reg_line_before_edge", bus.tx_line);
        @(posedge clk);
        #1;
        exp_q.push_back(1'b0);
        chk("reg_line_after_edge", bus.tx_line);

        // Select glitching between edges never reaches the pin.
        drive(SEL_STOP, 1'b0, 1'b1);
        #1;
        drive(SEL_PARITY, 1'b0, 1'b1);
        #1;
        drive(SEL_DATA, 1'b0, 1'b1);
        #1;
        exp_q.push_back(1'b0);
        chk("glitch_line_held", bus.tx_line);

        // Async reset mid-frame: line jumps to idle without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(1'b1);
        chk("arst_line_idle", bus.tx_line);
        exp_q.push_back(1'b0);
        chk("arst_packet_follows", bus.tx_packet);
        drive(SEL_PARITY, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        exp_q.push_back(1'b1);
        chk("arst_packet_parity", bus.tx_packet);
        exp_q.push_back(1'b1);
        chk("arst_line_held", bus.tx_line);

        @(negedge clk);
        rst_n = 1'b1;
        drive(SEL_START, 1'b1, 1'b1);
        #1;
        exp_q.push_back(1'b1);
        chk("release_line_before_edge", bus.tx_line);
        @(posedge clk);
        #1;
        exp_q.push_back(1'b0);
        chk("release_line_tracks", bus.tx_line);

        // Full frame: START, 0xA5 LSB first, even parity, STOP.
        frame_byte = 8'hA5;
        par        = ^frame_byte;
        frame_exp  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        frame_sel[0]  = SEL_START;
        frame_d[0]    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame_sel[i+1] = SEL_DATA;
            frame_d[i+1]   = frame_byte[i];
        end
        frame_sel[9]  = SEL_PARITY;
        frame_d[9]    = 1'b1;
        frame_sel[10] = SEL_STOP;
        frame_d[10]   = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(frame_sel[i], frame_d[i], par);
            exp_q.push_back(frame_exp[i]);
            @(posedge clk);
            #1;
            chk($sformatf("frame_bit%0d", i), bus.tx_line);
        end

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tx_mux
